// File: rtl/dcache_pkg.sv
// Shared types for the write-through data cache: FSM state encoding and address-split widths.
package dcache_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        WRITE = 2'd2
    } state_t;

    function automatic int idxW(input int lines);
        return $clog2(lines);
    endfunction

    function automatic int tagW(input int addrW, input int lines);
        return addrW - $clog2(lines) - 2;
    endfunction

endpackage

// File: rtl/dcache_line_store.sv
// Line storage: valid bits (async-cleared), tags and data words; combinational read, one write port.
// wrAlloc marks a fill (tag + valid written too); a plain write touches only the data word.
module dcache_line_store
    import dcache_pkg::*;
#(
    parameter int LINES  = 16,
    parameter int ADDR_W = 32,
    localparam int IDX_W = idxW(LINES),
    localparam int TAG_W = tagW(ADDR_W, LINES)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [IDX_W-1:0]  rdIdx,
    output logic              rdValid,
    output logic [TAG_W-1:0]  rdTag,
    output logic [ADDR_W-1:0] rdData,
    input  logic              wrEn,
    input  logic              wrAlloc,
    input  logic [IDX_W-1:0]  wrIdx,
    input  logic [TAG_W-1:0]  wrTag,
    input  logic [ADDR_W-1:0] wrData
);

    logic [LINES-1:0]  validArr;
    logic [TAG_W-1:0]  tagArr  [LINES];
    logic [ADDR_W-1:0] dataArr [LINES];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            validArr <= '0;
        end else if (wrEn && wrAlloc) begin
            validArr[wrIdx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wrEn) begin
            dataArr[wrIdx] <= wrData;
            if (wrAlloc) begin
                tagArr[wrIdx] <= wrTag;
            end
        end
    end

    assign rdValid = validArr[rdIdx];
    assign rdTag   = tagArr[rdIdx];
    assign rdData  = dataArr[rdIdx];

endmodule

// File: rtl/dcache_wt.sv
// Direct-mapped write-through, no-write-allocate D-cache; hits in 0 cycles, fill = ack + 1 cycle.
// stall holds the core during fills and write-throughs; DCACHE_STATS_EN adds hit/miss counters.
module dcache_wt
    import dcache_pkg::*;
#(
    parameter int LINES  = 16,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              memRead,
    input  logic              memWrite,
    input  logic [ADDR_W-1:0] address,
    input  logic [ADDR_W-1:0] writeData,
    output logic [ADDR_W-1:0] readData,
    output logic              stall,
    output logic              memReq,
    output logic              memWe,
    output logic [ADDR_W-1:0] memAddr,
    output logic [ADDR_W-1:0] memWData,
    input  logic              memAck,
    input  logic [ADDR_W-1:0] memRData
`ifdef DCACHE_STATS_EN
    ,
    output logic [31:0]       hitCount,
    output logic [31:0]       missCount
`endif
);

    localparam int IDX_W = idxW(LINES);
    localparam int TAG_W = tagW(ADDR_W, LINES);

    state_t            state;
    logic [IDX_W-1:0]  idx;
    logic [TAG_W-1:0]  tag;
    logic [ADDR_W-1:0] alignedAddr;
    logic              lineValid;
    logic [TAG_W-1:0]  lineTag;
    logic [ADDR_W-1:0] lineData;
    logic              hit;
    logic              fillDone;
    logic              storeHit;
    logic              wrEn;
    logic [IDX_W-1:0]  wrIdx;
    logic [ADDR_W-1:0] wrData;
    logic              unusedByteOffset;

    assign idx              = address[IDX_W+1:2];
    assign tag              = address[ADDR_W-1:IDX_W+2];
    assign alignedAddr      = {address[ADDR_W-1:2], 2'b00};
    assign unusedByteOffset = ^address[1:0];

    assign hit      = lineValid && (lineTag == tag);
    assign readData = hit ? lineData : '0;

    // Fill index/tag come from the latched request so the write lands where the miss was taken.
    assign fillDone = (state == FILL) && memAck;
    assign storeHit = (state == IDLE) && memWrite && hit;
    assign wrEn     = fillDone || storeHit;
    assign wrIdx    = fillDone ? memAddr[IDX_W+1:2] : idx;
    assign wrData   = fillDone ? memRData : writeData;

    dcache_line_store #(
        .LINES  (LINES),
        .ADDR_W (ADDR_W)
    ) u_lineStore (
        .clk     (clk),
        .rst     (rst),
        .rdIdx   (idx),
        .rdValid (lineValid),
        .rdTag   (lineTag),
        .rdData  (lineData),
        .wrEn    (wrEn),
        .wrAlloc (fillDone),
        .wrIdx   (wrIdx),
        .wrTag   (memAddr[ADDR_W-1:IDX_W+2]),
        .wrData  (wrData)
    );

    always_comb begin
        stall = 1'b0;
        unique case (state)
            IDLE:    stall = memWrite || (memRead && !hit);
            FILL:    stall = 1'b1;
            WRITE:   stall = !memAck;
            default: stall = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            memReq   <= 1'b0;
            memWe    <= 1'b0;
            memAddr  <= '0;
            memWData <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (memWrite) begin
                        memReq   <= 1'b1;
                        memWe    <= 1'b1;
                        memAddr  <= alignedAddr;
                        memWData <= writeData;
                        state    <= WRITE;
                    end else if (memRead && !hit) begin
                        memReq  <= 1'b1;
                        memWe   <= 1'b0;
                        memAddr <= alignedAddr;
                        state   <= FILL;
                    end
                end
                FILL, WRITE: begin
                    if (memAck) begin
                        memReq <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef DCACHE_STATS_EN
    // Loads only: a store with memRead also set is a store.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hitCount  <= '0;
            missCount <= '0;
        end else if (state == IDLE && memRead && !memWrite) begin
            if (hit) begin
                hitCount <= hitCount + 32'd1;
            end else begin
                missCount <= missCount + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_dcache_wt.sv
module tb_dcache_wt;

    logic        clk = 1'b0;
    logic        rst;
    logic        memRead, memWrite;
    logic [31:0] address, writeData, readData;
    logic        stall, memReq, memWe, memAck;
    logic [31:0] memAddr, memWData, memRData;
`ifdef DCACHE_STATS_EN
    logic [31:0] hitCount, missCount;
`endif

    always #5 clk = ~clk;

    dcache_wt #(.LINES(16), .ADDR_W(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .memRead   (memRead),
        .memWrite  (memWrite),
        .address   (address),
        .writeData (writeData),
        .readData  (readData),
        .stall     (stall),
        .memReq    (memReq),
        .memWe     (memWe),
        .memAddr   (memAddr),
        .memWData  (memWData),
        .memAck    (memAck),
        .memRData  (memRData)
`ifdef DCACHE_STATS_EN
        ,
        .hitCount  (hitCount),
        .missCount (missCount)
`endif
    );

    int nVec  = 0;
    int nFail = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nVec++;
        if (got !== exp) begin
            nFail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference: which word address each index holds, plus a sparse backing memory.
    bit          cValid [16];
    logic [31:0] cAddr  [16];
    logic [31:0] cData  [16];
    logic [31:0] mem [logic [31:0]];
    int          expHits   = 0;
    int          expMisses = 0;

    function automatic logic [31:0] wordOf(input logic [31:0] a);
        return a & 32'hFFFF_FFFC;
    endfunction

    function automatic int slotOf(input logic [31:0] a);
        return int'((a >> 2) % 16);
    endfunction

    function automatic logic [31:0] memVal(input logic [31:0] wa);
        if (mem.exists(wa)) return mem[wa];
        return (wa * 32'd2654435761) ^ 32'h5A5A_0F0F;
    endfunction

    function automatic bit mHit(input logic [31:0] a);
        return cValid[slotOf(a)] && cAddr[slotOf(a)] == wordOf(a);
    endfunction

    task automatic clearModel();
        for (int k = 0; k < 16; k++) cValid[k] = 1'b0;
    endtask

    task automatic checkStats(input string tag);
`ifdef DCACHE_STATS_EN
        check({tag, "_hitCount"},  hitCount,  expHits);
        check({tag, "_missCount"}, missCount, expMisses);
`else
        if (tag.len() < 0) $display("%s", tag);
`endif
    endtask

    task automatic idleCycle();
        @(negedge clk);
        memRead  = 1'b0;
        memWrite = 1'b0;
        #1;
        check("idleStall", stall, 1'b0);
        check("idleReq", memReq, 1'b0);
    endtask

    task automatic doRead(input logic [31:0] a, input int delay, input bit abortWithReset);
        logic [31:0] wa;
        int          s;
        wa = wordOf(a);
        s  = slotOf(a);
        @(negedge clk);
        memRead  = 1'b1;
        memWrite = 1'b0;
        address  = a;
        #1;
        if (mHit(a)) begin
            check("hitStall", stall, 1'b0);
            check("hitData", readData, cData[s]);
            check("hitNoReq", memReq, 1'b0);
            expHits++;
            @(posedge clk);
            return;
        end
        check("missStall", stall, 1'b1);
        check("missData", readData, 32'd0);
        expMisses++;
        @(negedge clk);
        check("fillReq", memReq, 1'b1);
        check("fillWe", memWe, 1'b0);
        check("fillAddr", memAddr, wa);
        check("fillStall", stall, 1'b1);
        if (abortWithReset) begin
            checkStats("preReset");
            rst = 1'b0;
            #1;
            check("rstReqDrop", memReq, 1'b0);
            memRead = 1'b0;
            #1;
            check("rstStall", stall, 1'b0);
            check("rstData", readData, 32'd0);
            check("rstAddr", memAddr, 32'd0);
            clearModel();
            expHits   = 0;
            expMisses = 0;
            checkStats("inReset");
            @(negedge clk);
            rst = 1'b1;
            return;
        end
        repeat (delay) begin
            @(negedge clk);
            check("fillHold", memReq, 1'b1);
            check("fillHoldStall", stall, 1'b1);
        end
        memAck   = 1'b1;
        memRData = memVal(wa);
        #1;
        check("fillAckStall", stall, 1'b1);
        @(negedge clk);
        memAck   = 1'b0;
        memRData = 32'hBAD0_BAD0;
        cValid[s] = 1'b1;
        cAddr[s]  = wa;
        cData[s]  = memVal(wa);
        #1;
        check("postFillReq", memReq, 1'b0);
        check("postFillStall", stall, 1'b0);
        check("postFillData", readData, memVal(wa));
        expHits++;
    endtask

    task automatic doWrite(input logic [31:0] a, input logic [31:0] d, input int delay,
                           input bit alsoRead);
        logic [31:0] wa;
        wa = wordOf(a);
        @(negedge clk);
        memWrite  = 1'b1;
        memRead   = alsoRead;
        address   = a;
        writeData = d;
        #1;
        check("stStall", stall, 1'b1);
        @(negedge clk);
        check("stReq", memReq, 1'b1);
        check("stWe", memWe, 1'b1);
        check("stAddr", memAddr, wa);
        check("stWData", memWData, d);
        check("stStallW", stall, 1'b1);
        repeat (delay) begin
            @(negedge clk);
            check("stHold", memReq, 1'b1);
            check("stHoldStall", stall, 1'b1);
        end
        memAck = 1'b1;
        #1;
        check("stAckStall", stall, 1'b0);
        @(negedge clk);
        memAck   = 1'b0;
        memWrite = 1'b0;
        memRead  = 1'b0;
        #1;
        check("stDoneReq", memReq, 1'b0);
        mem[wa] = d;
        if (mHit(a)) cData[slotOf(a)] = d;
    endtask

    initial begin
        rst       = 1'b0;
        memRead   = 1'b0;
        memWrite  = 1'b0;
        address   = '0;
        writeData = '0;
        memAck    = 1'b0;
        memRData  = '0;
        clearModel();
        mem[32'h40] = 32'hDEAD_BEEF;
        repeat (2) @(negedge clk);
        check("rstStall0", stall, 1'b0);
        check("rstReq0", memReq, 1'b0);
        check("rstWe0", memWe, 1'b0);
        check("rstAddr0", memAddr, 32'd0);
        check("rstWData0", memWData, 32'd0);
        check("rstData0", readData, 32'd0);
        checkStats("rst0");
        rst = 1'b1;

        doRead(32'h10, 1, 1'b0);
        doRead(32'h40, 2, 1'b0);
        doRead(32'h42, 0, 1'b0);
        doWrite(32'h40, 32'h1234_5678, 1, 1'b0);
        doRead(32'h40, 0, 1'b0);
        doWrite(32'h200, 32'hCAFE_F00D, 0, 1'b0);
        doRead(32'h200, 1, 1'b0);
        doRead(32'h40, 0, 1'b0);
        doRead(32'h80, 2, 1'b0);
        doRead(32'h40, 3, 1'b1);
        doRead(32'h40, 0, 1'b0);
        idleCycle();

        for (int n = 0; n < 250; n++) begin
            logic [31:0] a;
            int          kind;
            a = ({30'd0, 2'($urandom_range(0, 3))} << 6) | ({28'd0, 4'($urandom_range(0, 15))} << 2)
                | {30'd0, 2'($urandom_range(0, 3))};
            kind = $urandom_range(0, 39);
            if (kind < 20)       doRead(a, $urandom_range(0, 3), 1'b0);
            else if (kind < 30)  doWrite(a, $urandom, $urandom_range(0, 3), 1'b0);
            else if (kind < 34)  doWrite(a, $urandom, $urandom_range(0, 3), 1'b1);
            else if (kind < 39)  idleCycle();
            else                 doRead(a, 0, 1'b1);
        end
        idleCycle();
        checkStats("final");

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nFail);
        $finish;
    end

endmodule
